// File: rtl/mont_pkg.sv
// mont_pkg: shared widths and a bench-side N' helper for the Montgomery reduction stage
package mont_pkg;
  localparam int W_DEFAULT = 8;
  localparam int PROD_W = 2 * W_DEFAULT;
  localparam int U_W = W_DEFAULT + 1;
  // Newton iteration doubles the correct low bits of N^-1 each step (3 -> 6 -> 12 -> 24).
  function automatic logic [W_DEFAULT-1:0] calc_nprime(input logic [W_DEFAULT-1:0] n);
    logic [W_DEFAULT-1:0] x;
    x = n;
    for (int i = 0; i < 3; i++) x = x * (W_DEFAULT'(2) - n * x);
    return -x;
  endfunction
endpackage

// File: rtl/mont_final_sub.sv
// mont_final_sub: conditional subtract u >= n ? u - n : u, W+1 bits in, W bits out
module mont_final_sub #(
  parameter int W = 8
) (
  input  logic [W:0]   u,
  input  logic [W-1:0] n,
  output logic [W-1:0] res
);
  // u < 2n, so the difference always fits in W bits.
  always_comb res = (u >= {1'b0, n}) ? u[W-1:0] - n : u[W-1:0];
endmodule

// File: rtl/mont_reduce_8.sv
// mont_reduce_8: 3-stage pipelined REDC (T*R^-1 mod N) with valid/ready on both sides
module mont_reduce_8
  import mont_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_t,
  input  logic [W-1:0]   in_n,
  input  logic [W-1:0]   in_nprime,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_res
);
  logic v1, v2, v3, r1, r2, r3;
  logic [2*W-1:0] t1;
  logic [W-1:0] n1, m1, n2, m_in, fin;
  logic [W:0] u2, u_next;
  logic [W-1:0] sum_lo_unused;
  logic [2*W:0] mn;
  assign r3 = !v3 | out_ready;
  assign r2 = !v2 | r3;
  assign r1 = !v1 | r2;
  assign in_ready = rst | r1;
  assign out_valid = v3;
  assign m_in = in_t[W-1:0] * in_nprime;
  assign mn = {{(W+1){1'b0}}, m1} * {{(W+1){1'b0}}, n1};
  // The low W bits of t + m*n are zero by construction of m.
  assign {u_next, sum_lo_unused} = {1'b0, t1} + mn;
  mont_final_sub #(.W(W)) u_sub (.u(u2), .n(n2), .res(fin));
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_res <= '0;
    end else begin
      if (r1) begin
        v1 <= in_valid;
        if (in_valid) begin
          t1 <= in_t;
          n1 <= in_n;
          m1 <= m_in;
        end
      end
      if (r2) begin
        v2 <= v1;
        if (v1) begin
          u2 <= u_next;
          n2 <= n1;
        end
      end
      if (r3) begin
        v3 <= v2;
        if (v2) out_res <= fin;
      end
    end
  end
endmodule
